// File: rtl/mips_regfile_bypass.sv
// Two-write-port MIPS register file with same-cycle bypass, hardwired zero
// register and a per-register pending scoreboard for load-use stalls.
module mips_regfile_bypass #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_stall,
   input  logic                       wa_en,
   input  logic [ADDR_W-1:0]          wa_addr,
   input  logic [DATA_W-1:0]          wa_data,
   input  logic                       wb_en,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic                       pend_set,
   input  logic [ADDR_W-1:0]          pend_addr,
   output logic [ADDR_W:0]            pend_cnt,
   output logic                       err_dbl
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  pend_nxt;

   logic wa_ok, wb_ok, set_ok;
   logic cnt_inc, cnt_dec, dbl_hit;

   // Qualify each write/set against the hardwired zero register
   always_comb begin
      wa_ok   = wa_en;
      wb_ok   = wb_en;
      set_ok  = pend_set;
      if (ZERO_REG != 0) begin
         if (wa_addr == '0)   wa_ok  = 1'b0;
         if (wb_addr == '0)   wb_ok  = 1'b0;
         if (pend_addr == '0) set_ok = 1'b0;
      end
   end

   // Scoreboard next state: writeback clears, a new load set overrides it
   always_comb begin
      pend_nxt = pend;
      cnt_inc  = 1'b0;
      cnt_dec  = 1'b0;
      dbl_hit  = 1'b0;
      if (wb_ok) pend_nxt[wb_addr] = 1'b0;
      if (set_ok) pend_nxt[pend_addr] = 1'b1;
      if (set_ok && !pend[pend_addr]) cnt_inc = 1'b1;
      if (set_ok && pend[pend_addr])  dbl_hit = 1'b1;
      if (wb_ok && pend[wb_addr] && !(set_ok && (pend_addr == wb_addr)))
         cnt_dec = 1'b1;
   end

   // Register array; port A wins when both ports hit the same address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
      end else begin
         if (wb_ok && !(wa_ok && (wa_addr == wb_addr))) regs[wb_addr] <= wb_data;
         if (wa_ok) regs[wa_addr] <= wa_data;
      end
   end

   // Pending bits, incremental pending count and sticky double-set flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend     <= '0;
         pend_cnt <= '0;
         err_dbl  <= 1'b0;
      end else begin
         pend     <= pend_nxt;
         pend_cnt <= pend_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
         if (dbl_hit) err_dbl <= 1'b1;
      end
   end

   for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              s;

      assign ra = rd_addr[i*ADDR_W +: ADDR_W];

      // Read mux: bypass A, then B, then array; zero register overrides all
      always_comb begin
         d = regs[ra];
         s = pend[ra];
         if (BYPASS != 0) begin
            if (wa_en && (wa_addr == ra))      d = wa_data;
            else if (wb_en && (wb_addr == ra)) d = wb_data;
            if (wb_en && (wb_addr == ra))      s = 1'b0;
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            d = '0;
            s = 1'b0;
         end
      end

      assign rd_data[i*DATA_W +: DATA_W] = d;
      assign rd_stall[i]                 = s;
   end

endmodule
